// File: rtl/psola_output_reader.sv
// Streams a finished PSOLA output buffer out of BRAM as saturated audio samples, one per tick,
// clearing each location after it is read. Define PSOLA_READER_ROUND_EN for round-half-up conversion.
module psola_output_reader #(
    parameter int WINDOW_SIZE = 2048,
    parameter int OUT_WIDTH   = 16,
    parameter int FRAC_BITS   = 10,
    localparam int LOG_WINDOW_SIZE = $clog2(WINDOW_SIZE)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [11:0]                   window_len_in,
    input  logic                          window_len_valid_in,
    input  logic                          sample_tick_in,
    output logic [LOG_WINDOW_SIZE:0]      read_addr,
    input  logic signed [31:0]            read_data_in,
    output logic [LOG_WINDOW_SIZE:0]      write_addr,
    output logic [31:0]                   write_val,
    output logic                          valid_write,
    output logic signed [OUT_WIDTH-1:0]   audio_out,
    output logic                          audio_valid_out,
    output logic                          busy_out,
    output logic                          buffer_done_out,
    output logic                          overrun_out
);

    localparam int ADDR_W = LOG_WINDOW_SIZE + 1;

`ifdef PSOLA_READER_ROUND_EN
    localparam logic signed [32:0] ROUND_BIAS = 33'sd1 <<< (FRAC_BITS - 1);
`else
    localparam logic signed [32:0] ROUND_BIAS = 33'sd0;
`endif
    localparam logic signed [32:0] SAT_MAX = (33'sd1 <<< (OUT_WIDTH - 1)) - 33'sd1;
    localparam logic signed [32:0] SAT_MIN = -(33'sd1 <<< (OUT_WIDTH - 1));

    typedef enum logic [2:0] {IDLE, WAIT_TICK, ISSUE, LAT1, CAPTURE, DONE} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_W-1:0]            len_q, len_d;
    logic [ADDR_W-1:0]            idx_q, idx_d;
    logic [ADDR_W-1:0]            pend_len_q, pend_len_d;
    logic                         pend_len_vld_q, pend_len_vld_d;
    logic                         pend_tick_q, pend_tick_d;
    logic                         overrun_q, overrun_d;
    logic signed [OUT_WIDTH-1:0]  audio_q, audio_d;
    logic                         audio_vld_q, audio_vld_d;
    logic                         wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]            wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]            len_clamped;
    logic                         busy;

    // Widened by one bit so the rounding bias cannot overflow a full-scale positive word.
    function automatic logic signed [OUT_WIDTH-1:0] to_sample(input logic signed [31:0] acc);
        logic signed [32:0] biased;
        logic signed [32:0] shifted;
        biased  = {acc[31], acc} + ROUND_BIAS;
        shifted = biased >>> FRAC_BITS;
        if (shifted > SAT_MAX)
            return OUT_WIDTH'(SAT_MAX);
        else if (shifted < SAT_MIN)
            return OUT_WIDTH'(SAT_MIN);
        else
            return OUT_WIDTH'(shifted);
    endfunction

    assign len_clamped = (32'(window_len_in) > WINDOW_SIZE) ? ADDR_W'(WINDOW_SIZE)
                                                             : ADDR_W'(window_len_in);
    assign busy = (state_q == WAIT_TICK) || (state_q == ISSUE) ||
                  (state_q == LAT1)      || (state_q == CAPTURE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d        = state_q;
        len_d          = len_q;
        idx_d          = idx_q;
        pend_len_d     = pend_len_q;
        pend_len_vld_d = pend_len_vld_q;
        pend_tick_d    = pend_tick_q;
        overrun_d      = overrun_q;
        audio_d        = audio_q;
        audio_vld_d    = 1'b0;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;

        if (busy && (state_q != WAIT_TICK) && sample_tick_in) begin
            if (pend_tick_q) overrun_d   = 1'b1;
            else             pend_tick_d = 1'b1;
        end
        if (busy && window_len_valid_in) begin
            pend_len_d     = len_clamped;
            pend_len_vld_d = 1'b1;
            if (pend_len_vld_q) overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (window_len_valid_in) begin
                    len_d   = len_clamped;
                    idx_d   = '0;
                    state_d = (len_clamped == '0) ? DONE : WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (sample_tick_in || pend_tick_q) begin
                    state_d     = ISSUE;
                    pend_tick_d = sample_tick_in && pend_tick_q;
                end
            end
            ISSUE:   state_d = LAT1;
            LAT1:    state_d = CAPTURE;
            CAPTURE: begin
                audio_d     = to_sample(read_data_in);
                audio_vld_d = 1'b1;
                wr_en_d     = 1'b1;
                wr_addr_d   = idx_q;
                if (idx_q == len_q - ADDR_W'(1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = WAIT_TICK;
                end
            end
            DONE: begin
                // Ticks left over from the finished buffer do not carry into the next one.
                pend_tick_d = 1'b0;
                if (pend_len_vld_q) begin
                    len_d          = pend_len_q;
                    idx_d          = '0;
                    state_d        = (pend_len_q == '0) ? DONE : WAIT_TICK;
                    pend_len_vld_d = window_len_valid_in;
                    pend_len_d     = window_len_valid_in ? len_clamped : pend_len_q;
                end else if (window_len_valid_in) begin
                    len_d   = len_clamped;
                    idx_d   = '0;
                    state_d = (len_clamped == '0) ? DONE : WAIT_TICK;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= IDLE;
            len_q          <= '0;
            idx_q          <= '0;
            pend_len_q     <= '0;
            pend_len_vld_q <= 1'b0;
            pend_tick_q    <= 1'b0;
            overrun_q      <= 1'b0;
            audio_q        <= '0;
            audio_vld_q    <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q        <= state_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            pend_len_q     <= pend_len_d;
            pend_len_vld_q <= pend_len_vld_d;
            pend_tick_q    <= pend_tick_d;
            overrun_q      <= overrun_d;
            audio_q        <= audio_d;
            audio_vld_q    <= audio_vld_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
        end
    end

    assign read_addr       = (state_q == ISSUE) ? idx_q : '0;
    assign write_addr      = wr_addr_q;
    assign write_val       = '0;
    assign valid_write     = wr_en_q;
    assign audio_out       = audio_q;
    assign audio_valid_out = audio_vld_q;
    assign busy_out        = busy;
    assign buffer_done_out = (state_q == DONE);
    assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_psola_output_reader.sv
// Directed self-checking bench for psola_output_reader with a two-cycle-latency BRAM model.
module tb_psola_output_reader;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic [11:0]        window_len_in;
    logic               window_len_valid_in;
    logic               sample_tick_in;
    logic [11:0]        read_addr;
    logic signed [31:0] read_data_in;
    logic [11:0]        write_addr;
    logic [31:0]        write_val;
    logic               valid_write;
    logic signed [15:0] audio_out;
    logic               audio_valid_out;
    logic               busy_out;
    logic               buffer_done_out;
    logic               overrun_out;

    int n_total = 0;
    int n_pass  = 0;

    logic signed [31:0] mem [0:4095];
    logic signed [31:0] rd_p1, rd_p2;
    logic signed [15:0] aud_log[$];
    logic [11:0]        wr_addr_log[$];
    logic [31:0]        wr_val_log[$];
    int                 done_cnt = 0;

    psola_output_reader dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .window_len_in       (window_len_in),
        .window_len_valid_in (window_len_valid_in),
        .sample_tick_in      (sample_tick_in),
        .read_addr           (read_addr),
        .read_data_in        (read_data_in),
        .write_addr          (write_addr),
        .write_val           (write_val),
        .valid_write         (valid_write),
        .audio_out           (audio_out),
        .audio_valid_out     (audio_valid_out),
        .busy_out            (busy_out),
        .buffer_done_out     (buffer_done_out),
        .overrun_out         (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        rd_p1 <= mem[read_addr];
        rd_p2 <= rd_p1;
    end
    assign read_data_in = rd_p2;

    always @(negedge clk_in) begin
        if (audio_valid_out) aud_log.push_back(audio_out);
        if (valid_write) begin
            wr_addr_log.push_back(write_addr);
            wr_val_log.push_back(write_val);
        end
        if (buffer_done_out) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        step(2);
        rst_in = 1'b1;
        step(1);
    endtask

    task automatic start_len(input int len);
        window_len_in       = 12'(len);
        window_len_valid_in = 1'b1;
        step(1);
        window_len_valid_in = 1'b0;
    endtask

    // One tick, then wait (bounded) for the sample; lat counts edges from the tick edge.
    task automatic fetch(output logic signed [15:0] val, output int lat,
                         output logic [11:0] raddr, output logic done);
        sample_tick_in = 1'b1;
        step(1);
        sample_tick_in = 1'b0;
        raddr = read_addr;
        lat   = 1;
        while (audio_valid_out !== 1'b1 && lat < 16) begin
            step(1);
            lat++;
        end
        val  = audio_out;
        done = buffer_done_out;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        step(2);
        n_total++;
        if ({read_addr, write_addr, write_val, valid_write, audio_out, audio_valid_out,
             busy_out, buffer_done_out, overrun_out} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b ovr=%b raddr=%0d audio=%0d expected all 0",
                     busy_out, buffer_done_out, overrun_out, read_addr, audio_out);
        else n_pass++;
        rst_in = 1'b1;
        step(1);
    endtask

    task automatic test_stream_basic();
        int exp_val [4] = '{1, -2, 32767, -32768};
        logic signed [15:0] val;
        logic [11:0] raddr;
        logic done;
        int lat;
        int wbase;
        do_reset();
        wbase  = wr_addr_log.size();
        mem[0] = 32'sd1024;
        mem[1] = -32'sd2048;
        mem[2] = 32'h7FFF_FC00;
        mem[3] = 32'h8000_0000;
        start_len(4);
        n_total++;
        if (busy_out !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy_out);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step(16);
            fetch(val, lat, raddr, done);
            n_total++;
            if (val !== 16'(exp_val[i]))
                $display("FAIL basic_val[%0d]: got %0d expected %0d", i, val, exp_val[i]);
            else n_pass++;
            n_total++;
            if (lat !== 4) $display("FAIL basic_latency[%0d]: got %0d expected 4", i, lat);
            else n_pass++;
            n_total++;
            if (raddr !== 12'(i)) $display("FAIL basic_raddr[%0d]: got %0d expected %0d", i, raddr, i);
            else n_pass++;
            n_total++;
            if (done !== (i == 3)) $display("FAIL basic_done[%0d]: got %b expected %b", i, done, i == 3);
            else n_pass++;
        end
        step(1);
        n_total++;
        if ({audio_valid_out, valid_write, buffer_done_out, busy_out} !== 4'b0000)
            $display("FAIL basic_after: got valid=%b wr=%b done=%b busy=%b expected 0000",
                     audio_valid_out, valid_write, buffer_done_out, busy_out);
        else n_pass++;
        n_total++;
        if (wr_addr_log.size() !== wbase + 4)
            $display("FAIL basic_clear_count: got %0d expected %0d", wr_addr_log.size() - wbase, 4);
        else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_total++;
                if (wr_addr_log[wbase + i] !== 12'(i) || wr_val_log[wbase + i] !== 32'd0)
                    $display("FAIL basic_clear[%0d]: got addr %0d val %0d expected addr %0d val 0",
                             i, wr_addr_log[wbase + i], wr_val_log[wbase + i], i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_rounding();
        logic signed [31:0] word [3] = '{32'sd1535, 32'sd1536, -32'sd1};
`ifdef PSOLA_READER_ROUND_EN
        int exp_val [3] = '{1, 2, 0};
`else
        int exp_val [3] = '{1, 1, -1};
`endif
        logic signed [15:0] val;
        logic [11:0] raddr;
        logic done;
        int lat;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem[0] = word[i];
            start_len(1);
            step(2);
            fetch(val, lat, raddr, done);
            n_total++;
            if (val !== 16'(exp_val[i]) || done !== 1'b1)
                $display("FAIL round[%0d]: got %0d done %b expected %0d done 1", i, val, done, exp_val[i]);
            else n_pass++;
            step(3);
        end
    endtask

    task automatic test_len_zero();
        int abase, wbase;
        do_reset();
        abase = aud_log.size();
        wbase = wr_addr_log.size();
        start_len(0);
        n_total++;
        if (buffer_done_out !== 1'b1 || busy_out !== 1'b0)
            $display("FAIL zero_done: got done=%b busy=%b expected done=1 busy=0", buffer_done_out, busy_out);
        else n_pass++;
        step(1);
        n_total++;
        if (buffer_done_out !== 1'b0) $display("FAIL zero_pulse: got %b expected 0", buffer_done_out);
        else n_pass++;
        step(4);
        n_total++;
        if (aud_log.size() !== abase || wr_addr_log.size() !== wbase)
            $display("FAIL zero_no_access: got %0d samples %0d writes expected 0 0",
                     aud_log.size() - abase, wr_addr_log.size() - wbase);
        else n_pass++;
    endtask

    task automatic test_tick_overrun();
        int abase, dbase, waited;
        do_reset();
        mem[0] = -32'sd1024;
        mem[1] = 32'sd10240;
        abase  = aud_log.size();
        dbase  = done_cnt;
        start_len(2);
        n_total++;
        if (overrun_out !== 1'b0) $display("FAIL ovr_tick_initial: got %b expected 0", overrun_out);
        else n_pass++;
        sample_tick_in = 1'b1;
        step(3);
        sample_tick_in = 1'b0;
        n_total++;
        if (overrun_out !== 1'b1) $display("FAIL ovr_tick_set: got %b expected 1", overrun_out);
        else n_pass++;
        waited = 0;
        while (aud_log.size() < abase + 2 && waited < 30) begin
            step(1);
            waited++;
        end
        step(5);
        n_total++;
        if (aud_log.size() !== abase + 2)
            $display("FAIL ovr_tick_count: got %0d samples expected 2", aud_log.size() - abase);
        else begin
            n_pass++;
            n_total++;
            if (aud_log[abase] !== -16'sd1 || aud_log[abase + 1] !== 16'sd10)
                $display("FAIL ovr_tick_vals: got %0d,%0d expected -1,10", aud_log[abase], aud_log[abase + 1]);
            else n_pass++;
        end
        n_total++;
        if (done_cnt !== dbase + 1 || busy_out !== 1'b0)
            $display("FAIL ovr_tick_done: got %0d done pulses busy=%b expected 1 busy=0", done_cnt - dbase, busy_out);
        else n_pass++;
        n_total++;
        if (overrun_out !== 1'b1) $display("FAIL ovr_tick_sticky: got %b expected 1", overrun_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int exp_val [5] = '{3, 4, 5, 3, 4};
        logic signed [15:0] val;
        logic [11:0] raddr;
        logic done;
        int lat;
        do_reset();
        mem[0] = 32'sd3072;
        mem[1] = 32'sd4096;
        mem[2] = 32'sd5120;
        start_len(3);
        for (int i = 0; i < 5; i++) begin
            fetch(val, lat, raddr, done);
            n_total++;
            if (val !== 16'(exp_val[i]) || done !== (i == 2 || i == 4))
                $display("FAIL b2b_sample[%0d]: got %0d done %b expected %0d done %b",
                         i, val, done, exp_val[i], i == 2 || i == 4);
            else n_pass++;
            if (i == 0) begin
                start_len(2);
                n_total++;
                if (overrun_out !== 1'b0) $display("FAIL b2b_single_pending: got %b expected 0", overrun_out);
                else n_pass++;
            end
            if (i == 2 || i == 4) begin
                step(1);
                n_total++;
                if (busy_out !== 1'b1) $display("FAIL b2b_restart[%0d]: got %b expected 1", i, busy_out);
                else n_pass++;
            end
            if (i == 3) begin
                start_len(5);
                start_len(1);
                n_total++;
                if (overrun_out !== 1'b1) $display("FAIL b2b_len_overrun: got %b expected 1", overrun_out);
                else n_pass++;
            end
            step(3);
        end
        fetch(val, lat, raddr, done);
        n_total++;
        if (val !== 16'sd3 || raddr !== 12'd0 || done !== 1'b1)
            $display("FAIL b2b_overwritten_len: got %0d addr %0d done %b expected 3 addr 0 done 1", val, raddr, done);
        else n_pass++;
        step(1);
        n_total++;
        if (busy_out !== 1'b0 || buffer_done_out !== 1'b0)
            $display("FAIL b2b_idle: got busy=%b done=%b expected 0 0", busy_out, buffer_done_out);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic signed [15:0] val;
        logic [11:0] raddr;
        logic done;
        int lat;
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = 32'(i * 1024);
        start_len(8);
        for (int i = 0; i < 5; i++) fetch(val, lat, raddr, done);
        n_total++;
        if (val !== 16'sd4) $display("FAIL midrst_pre: got %0d expected 4", val);
        else n_pass++;
        sample_tick_in = 1'b1;
        step(1);
        sample_tick_in = 1'b0;
        n_total++;
        if (read_addr !== 12'd5 || busy_out !== 1'b1)
            $display("FAIL midrst_issue: got addr %0d busy %b expected 5 1", read_addr, busy_out);
        else n_pass++;
        #2;
        rst_in = 1'b0;
        #1;
        n_total++;
        if ({read_addr, write_addr, write_val, valid_write, audio_out, audio_valid_out,
             busy_out, buffer_done_out, overrun_out} !== '0)
            $display("FAIL midrst_outputs: got busy=%b raddr=%0d waddr=%0d audio=%0d expected all 0",
                     busy_out, read_addr, write_addr, audio_out);
        else n_pass++;
        step(2);
        rst_in = 1'b1;
        step(1);
        n_total++;
        if (busy_out !== 1'b0 || buffer_done_out !== 1'b0)
            $display("FAIL midrst_idle: got busy=%b done=%b expected 0 0", busy_out, buffer_done_out);
        else n_pass++;
        mem[0] = 32'sd7168;
        mem[1] = 32'sd8192;
        mem[2] = 32'sd9216;
        start_len(3);
        for (int i = 0; i < 3; i++) begin
            step(2);
            fetch(val, lat, raddr, done);
            n_total++;
            if (val !== 16'(7 + i) || raddr !== 12'(i) || lat !== 4)
                $display("FAIL midrst_restream[%0d]: got %0d addr %0d lat %0d expected %0d addr %0d lat 4",
                         i, val, raddr, lat, 7 + i, i);
            else n_pass++;
        end
    endtask

    initial begin
        rst_in              = 1'b0;
        window_len_in       = '0;
        window_len_valid_in = 1'b0;
        sample_tick_in      = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;

        test_reset();
        test_stream_basic();
        test_rounding();
        test_len_zero();
        test_tick_overrun();
        test_back_to_back();
        test_reset_midstream();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
